// File: rtl/ncl_muxn_sync_if.sv
// ncl_muxn_sync_if: dual-rail select/data bus and handshake for ncl_muxn_sync.
//   sel_t/sel_f  SW     dual-rail channel select       (master -> slave)
//   din_t/din_f  CH*W   dual-rail channel data         (master -> slave)
//   ki           1      downstream acknowledge         (master -> slave)
//   ko           1      upstream acknowledge           (slave -> master)
//   out_t/out_f  W      registered dual-rail output    (slave -> master)
//   err          1      sticky illegal-encoding flag   (slave -> master)
//   cnt          CW     delivered DATA wavefront count (slave -> master)
interface ncl_muxn_sync_if #(
   parameter int unsigned CH = 4,
   parameter int unsigned W  = 1,
   parameter int unsigned CW = 16
);
   localparam int unsigned SW = $clog2(CH);

   logic [SW-1:0]   sel_t;
   logic [SW-1:0]   sel_f;
   logic [CH*W-1:0] din_t;
   logic [CH*W-1:0] din_f;
   logic            ki;
   logic            ko;
   logic [W-1:0]    out_t;
   logic [W-1:0]    out_f;
   logic            err;
   logic [CW-1:0]   cnt;

   modport master (
      output sel_t, sel_f, din_t, din_f, ki,
      input  ko, out_t, out_f, err, cnt
   );

   modport slave (
      input  sel_t, sel_f, din_t, din_f, ki,
      output ko, out_t, out_f, err, cnt
   );
endinterface

// File: rtl/ncl_muxn_sync.sv
// ncl_muxn_sync: synchronous model of an NCL N-way dual-rail multiplexer.
// All select and data rails are synchronised, classified as a wavefront
// (DATA / NULL / partial / ILLEGAL) and handed through a 2-state handshake.
//   clk     single clock, rising edge
//   rst     asynchronous active-high reset
//   bus_if  ncl_muxn_sync_if.slave: sel/din dual-rail inputs, ki in,
//           ko / out_t / out_f / err / cnt registered outputs
module ncl_muxn_sync #(
   parameter int unsigned CH          = 4,
   parameter int unsigned W           = 1,
   parameter int unsigned SYNC_STAGES = 2,
   parameter int unsigned CW          = 16
) (
   input  logic               clk,
   input  logic               rst,
   ncl_muxn_sync_if.slave     bus_if
);
   localparam int unsigned SW = $clog2(CH);
   localparam int unsigned DW = CH * W;
   localparam int unsigned NR = SW + DW;

   localparam logic [0:0] S_NULL = 1'b0;
   localparam logic [0:0] S_DATA = 1'b1;

   logic [NR-1:0] raw_t;
   logic [NR-1:0] raw_f;
   logic [NR-1:0] rail_t;
   logic [NR-1:0] rail_f;

   assign raw_t = {bus_if.sel_t, bus_if.din_t};
   assign raw_f = {bus_if.sel_f, bus_if.din_f};

   // Synchroniser chain over every rail; depth 0 evaluates the pins directly
   generate
      if (SYNC_STAGES == 0) begin : g_nosync
         assign rail_t = raw_t;
         assign rail_f = raw_f;
      end else begin : g_sync
         logic [NR-1:0] t_q [SYNC_STAGES];
         logic [NR-1:0] f_q [SYNC_STAGES];

         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               for (int i = 0; i < int'(SYNC_STAGES); i++) begin
                  t_q[i] <= '0;
                  f_q[i] <= '0;
               end
            end else begin
               t_q[0] <= raw_t;
               f_q[0] <= raw_f;
               for (int i = 1; i < int'(SYNC_STAGES); i++) begin
                  t_q[i] <= t_q[i-1];
                  f_q[i] <= f_q[i-1];
               end
            end
         end

         assign rail_t = t_q[SYNC_STAGES-1];
         assign rail_f = f_q[SYNC_STAGES-1];
      end
   endgenerate

   // Wavefront classification over the synchronised rails
   logic          data_cmp_c;
   logic          null_cmp_c;
   logic          illegal_c;
   logic [SW-1:0] sel_c;
   logic [DW-1:0] dt_c;
   logic [DW-1:0] df_c;
   logic [W-1:0]  pick_t_c;
   logic [W-1:0]  pick_f_c;

   assign data_cmp_c = &(rail_t ^ rail_f);
   assign null_cmp_c = ~|(rail_t | rail_f);
   assign illegal_c  = |(rail_t & rail_f);
   assign sel_c      = rail_t[NR-1 -: SW];
   assign dt_c       = rail_t[DW-1:0];
   assign df_c       = rail_f[DW-1:0];
   assign pick_t_c   = dt_c[int'(sel_c) * int'(W) +: W];
   assign pick_f_c   = df_c[int'(sel_c) * int'(W) +: W];

   logic [0:0]    state_q, state_d;
   logic [W-1:0]  out_t_q, out_t_d;
   logic [W-1:0]  out_f_q, out_f_d;
   logic          ko_q, ko_d;
   logic          err_q, err_d;
   logic [CW-1:0] cnt_q, cnt_d;

   // State and output registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_NULL;
         out_t_q <= '0;
         out_f_q <= '0;
         ko_q    <= 1'b1;
         err_q   <= 1'b0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         out_t_q <= out_t_d;
         out_f_q <= out_f_d;
         ko_q    <= ko_d;
         err_q   <= err_d;
         cnt_q   <= cnt_d;
      end
   end

   // Next state: an illegal pair wins over any transition and freezes everything
   always_comb begin
      state_d = state_q;
      out_t_d = out_t_q;
      out_f_d = out_f_q;
      ko_d    = ko_q;
      err_d   = err_q;
      cnt_d   = cnt_q;
      if (!err_q) begin
         if (illegal_c) begin
            err_d = 1'b1;
         end else begin
            case (state_q)
               S_NULL: begin
                  if (data_cmp_c && bus_if.ki) begin
                     state_d = S_DATA;
                     out_t_d = pick_t_c;
                     out_f_d = pick_f_c;
                     ko_d    = 1'b0;
                     cnt_d   = cnt_q + CW'(1);
                  end
               end
               S_DATA: begin
                  if (null_cmp_c && !bus_if.ki) begin
                     state_d = S_NULL;
                     out_t_d = '0;
                     out_f_d = '0;
                     ko_d    = 1'b1;
                  end
               end
               default: state_d = S_NULL;
            endcase
         end
      end
   end

   assign bus_if.out_t = out_t_q;
   assign bus_if.out_f = out_f_q;
   assign bus_if.ko    = ko_q;
   assign bus_if.err   = err_q;
   assign bus_if.cnt   = cnt_q;
endmodule

// File: tb/tb_ncl_muxn_sync.sv
// tb_ncl_muxn_sync: directed vector table plus hand-written reset/illegal
// sequences for ncl_muxn_sync (CH=4, W=2, SYNC_STAGES=2, CW=2).
module tb_ncl_muxn_sync;
   localparam int unsigned CH = 4;
   localparam int unsigned W  = 2;
   localparam int unsigned CW = 2;

   // Channel data: ch3 t=10 f=01, ch2 t=01 f=10, ch1 t=00 f=11, ch0 t=11 f=00
   localparam logic [7:0] DT = 8'h93;
   localparam logic [7:0] DF = 8'h6C;

   logic clk;
   logic rst;
   int   n_vec;
   int   n_err;

   ncl_muxn_sync_if #(.CH(CH), .W(W), .CW(CW)) bus_if ();

   ncl_muxn_sync #(
      .CH(CH), .W(W), .SYNC_STAGES(2), .CW(CW)
   ) u_dut (
      .clk    (clk),
      .rst    (rst),
      .bus_if (bus_if)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      string      name;
      logic [1:0] sel_t;
      logic [1:0] sel_f;
      logic [7:0] din_t;
      logic [7:0] din_f;
      logic       ki;
      int         nclk;
      logic [1:0] e_t;
      logic [1:0] e_f;
      logic       e_ko;
      logic       e_err;
      logic [1:0] e_cnt;
   } vec_t;

   vec_t vecs [$];

   function automatic vec_t mk(string nm, logic [1:0] st, logic [1:0] sf,
                               logic [7:0] dt, logic [7:0] df, logic k, int n,
                               logic [1:0] et, logic [1:0] ef, logic eko,
                               logic eerr, logic [1:0] ecnt);
      vec_t v;
      v.name = nm; v.sel_t = st; v.sel_f = sf; v.din_t = dt; v.din_f = df;
      v.ki = k; v.nclk = n; v.e_t = et; v.e_f = ef; v.e_ko = eko;
      v.e_err = eerr; v.e_cnt = ecnt;
      return v;
   endfunction

   task automatic drive(logic [1:0] st, logic [1:0] sf, logic [7:0] dt,
                        logic [7:0] df, logic k);
      @(negedge clk);
      bus_if.sel_t = st;
      bus_if.sel_f = sf;
      bus_if.din_t = dt;
      bus_if.din_f = df;
      bus_if.ki    = k;
   endtask

   task automatic tick(int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic check(string nm, logic [1:0] et, logic [1:0] ef, logic eko,
                        logic eerr, logic [1:0] ecnt);
      logic [7:0] got;
      logic [7:0] exp;
      got = {bus_if.out_t, bus_if.out_f, bus_if.ko, bus_if.err, bus_if.cnt};
      exp = {et, ef, eko, eerr, ecnt};
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got t=%b f=%b ko=%b err=%b cnt=%0d, want t=%b f=%b ko=%b err=%b cnt=%0d",
                  nm, bus_if.out_t, bus_if.out_f, bus_if.ko, bus_if.err, bus_if.cnt,
                  et, ef, eko, eerr, ecnt);
      end
   endtask

   initial begin
      n_vec = 0;
      n_err = 0;
      rst   = 1'b1;
      bus_if.sel_t = '0; bus_if.sel_f = '0;
      bus_if.din_t = '0; bus_if.din_f = '0;
      bus_if.ki    = 1'b0;

      //                name            sel_t  sel_f  din_t       din_f  ki  n   t      f      ko    err   cnt
      vecs.push_back(mk("idle",         2'b00, 2'b00, 8'h00,      8'h00, 0,  1,  2'b00, 2'b00, 1'b1, 1'b0, 2'd0));
      vecs.push_back(mk("cap_lat2",     2'b10, 2'b01, DT,         DF,    1,  2,  2'b00, 2'b00, 1'b1, 1'b0, 2'd0));
      vecs.push_back(mk("cap_ch2",      2'b10, 2'b01, DT,         DF,    1,  1,  2'b01, 2'b10, 1'b0, 1'b0, 2'd1));
      vecs.push_back(mk("hold_data",    2'b10, 2'b01, DT,         DF,    1,  3,  2'b01, 2'b10, 1'b0, 1'b0, 2'd1));
      vecs.push_back(mk("null_ki1",     2'b00, 2'b00, 8'h00,      8'h00, 1,  4,  2'b01, 2'b10, 1'b0, 1'b0, 2'd1));
      vecs.push_back(mk("null_ki0",     2'b00, 2'b00, 8'h00,      8'h00, 0,  1,  2'b00, 2'b00, 1'b1, 1'b0, 2'd1));
      vecs.push_back(mk("data_ki0",     2'b01, 2'b10, DT,         DF,    0, 10,  2'b00, 2'b00, 1'b1, 1'b0, 2'd1));
      vecs.push_back(mk("ki_rise",      2'b01, 2'b10, DT,         DF,    1,  1,  2'b00, 2'b11, 1'b0, 1'b0, 2'd2));
      vecs.push_back(mk("rel_1",        2'b00, 2'b00, 8'h00,      8'h00, 0,  3,  2'b00, 2'b00, 1'b1, 1'b0, 2'd2));
      vecs.push_back(mk("cap_ch3",      2'b11, 2'b00, DT,         DF,    1,  3,  2'b10, 2'b01, 1'b0, 1'b0, 2'd3));
      vecs.push_back(mk("rel_2",        2'b00, 2'b00, 8'h00,      8'h00, 0,  3,  2'b00, 2'b00, 1'b1, 1'b0, 2'd3));
      vecs.push_back(mk("cap_wrap",     2'b00, 2'b11, DT,         DF,    1,  3,  2'b11, 2'b00, 1'b0, 1'b0, 2'd0));
      vecs.push_back(mk("rel_3",        2'b00, 2'b00, 8'h00,      8'h00, 0,  3,  2'b00, 2'b00, 1'b1, 1'b0, 2'd0));
      vecs.push_back(mk("partial",      2'b11, 2'b00, 8'h13,      DF,    1, 20,  2'b00, 2'b00, 1'b1, 1'b0, 2'd0));
      vecs.push_back(mk("complete_pre", 2'b11, 2'b00, DT,         DF,    1,  2,  2'b00, 2'b00, 1'b1, 1'b0, 2'd0));
      vecs.push_back(mk("complete_cap", 2'b11, 2'b00, DT,         DF,    1,  1,  2'b10, 2'b01, 1'b0, 1'b0, 2'd1));
      vecs.push_back(mk("partial_null", 2'b01, 2'b00, 8'h00,      8'h00, 0,  5,  2'b10, 2'b01, 1'b0, 1'b0, 2'd1));
      vecs.push_back(mk("rel_4",        2'b00, 2'b00, 8'h00,      8'h00, 0,  3,  2'b00, 2'b00, 1'b1, 1'b0, 2'd1));

      // Reset state while held, then release
      tick(3);
      check("reset_hold", 2'b00, 2'b00, 1'b1, 1'b0, 2'd0);
      @(negedge clk);
      rst = 1'b0;

      foreach (vecs[i]) begin
         drive(vecs[i].sel_t, vecs[i].sel_f, vecs[i].din_t, vecs[i].din_f, vecs[i].ki);
         tick(vecs[i].nclk);
         check(vecs[i].name, vecs[i].e_t, vecs[i].e_f, vecs[i].e_ko, vecs[i].e_err, vecs[i].e_cnt);
      end

      // Illegal pair while in S_DATA: err sets after 3 clocks, data frozen
      drive(2'b10, 2'b01, DT, DF, 1'b1);
      tick(3);
      check("ill_cap", 2'b01, 2'b10, 1'b0, 1'b0, 2'd2);
      drive(2'b00, 2'b00, 8'h01, 8'h01, 1'b0);
      tick(2);
      check("ill_pre", 2'b01, 2'b10, 1'b0, 1'b0, 2'd2);
      tick(1);
      check("ill_set", 2'b01, 2'b10, 1'b0, 1'b1, 2'd2);
      drive(2'b00, 2'b00, 8'h00, 8'h00, 1'b0);
      tick(5);
      check("ill_frz_null", 2'b01, 2'b10, 1'b0, 1'b1, 2'd2);
      drive(2'b11, 2'b00, DT, DF, 1'b1);
      tick(5);
      check("ill_frz_data", 2'b01, 2'b10, 1'b0, 1'b1, 2'd2);

      // Asynchronous reset mid-cycle clears err immediately
      #2 rst = 1'b1;
      #1 check("rst_clr_err", 2'b00, 2'b00, 1'b1, 1'b0, 2'd0);
      @(negedge clk);
      rst = 1'b0;

      // Reset mid-wavefront discards it; a fresh wavefront refills the synchroniser
      drive(2'b01, 2'b10, DT, DF, 1'b1);
      tick(1);
      #2 rst = 1'b1;
      #1 check("rst_mid_wave", 2'b00, 2'b00, 1'b1, 1'b0, 2'd0);
      @(negedge clk);
      rst = 1'b0;
      tick(2);
      check("post_rst_pre", 2'b00, 2'b00, 1'b1, 1'b0, 2'd0);
      tick(1);
      check("post_rst_cap", 2'b00, 2'b11, 1'b0, 1'b0, 2'd1);

      // Reset while in S_DATA
      #2 rst = 1'b1;
      #1 check("rst_in_data", 2'b00, 2'b00, 1'b1, 1'b0, 2'd0);
      @(negedge clk);
      rst = 1'b0;
      drive(2'b00, 2'b00, 8'h00, 8'h00, 1'b0);
      tick(2);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule

// File: doc/ncl_muxn_sync.md
NCL_MUXN_SYNC -- requirements
Module: ncl_muxn_sync

Interface
REQ-001 Parameter CH, default 4, number of dual-rail input channels; power of two, 2 to 64.
REQ-002 Parameter W, default 1, dual-rail bits per channel.
REQ-003 Parameter SYNC_STAGES, default 2, input synchroniser depth; legal values 0, 2 and 3.
REQ-004 Parameter CW, default 16, wavefront counter width.
REQ-005 Localparam SW = clog2(CH), select width.
REQ-006 clk  in  1  single clock; all state changes on rising edge.
REQ-007 rst  in  1  asynchronous, active-high reset.
REQ-008 sel_t / sel_f  in  SW each  dual-rail select.
REQ-009 din_t / din_f  in  CH*W each  dual-rail data; channel k occupies bits [k*W +: W].
REQ-010 ki  in  1  downstream acknowledge; 1 = request-for-data, 0 = request-for-null.
REQ-011 ko  out  1  upstream acknowledge; 1 = request-for-data, 0 = request-for-null.
REQ-012 out_t / out_f  out  W each  registered dual-rail output.
REQ-013 err  out  1  sticky illegal-encoding flag.
REQ-014 cnt  out  CW  count of DATA wavefronts delivered.

Function
REQ-015 Every sel/din rail passes through SYNC_STAGES flops before evaluation; with SYNC_STAGES=0, rails are evaluated directly.
REQ-016 Rail pair classification: 01 or 10 = DATA, 00 = NULL, 11 = ILLEGAL.
REQ-017 DATA-complete = every sel pair and every din pair of every channel is DATA; NULL-complete = all such rails are 0.
REQ-018 Any other mix without an ILLEGAL pair is partial; partial wavefronts cause no state change.
REQ-019 FSM states: S_NULL (output NULL, ko=1) and S_DATA (output valid, ko=0).
REQ-020 S_NULL -> S_DATA when DATA-complete and ki=1: out_t/out_f load channel sel_t, ko<=0, cnt<=cnt+1.
REQ-021 S_DATA -> S_NULL when NULL-complete and ki=0: out_t<=0, out_f<=0, ko<=1.
REQ-022 The FSM evaluates the ki and wavefront conditions on the same edge; both must hold, otherwise the state holds.
REQ-023 Latency from a complete wavefront on the pins to the output/ko update = SYNC_STAGES+1 clocks.
REQ-024 Outputs hold between transitions; the DATA output never changes while in S_DATA.
REQ-025 cnt wraps from 2^CW-1 to 0 with no flag.
REQ-026 ILLEGAL on any synchronised pair sets err=1 on the next edge.
REQ-027 While err=1, FSM, outputs and cnt are frozen until reset.
REQ-028 ILLEGAL takes priority over any transition on the same edge.

Reset
REQ-029 rst=1 immediately forces: state S_NULL, out_t=0, out_f=0, ko=1, err=0, cnt=0, all synchroniser flops 0.
REQ-030 Reset asserted mid-wavefront discards that wavefront.
REQ-031 After rst falls, the first capture requires a fresh DATA-complete wavefront sampled through the full synchroniser.

Verification
REQ-032 Reset: rst pulse at any time -> same cycle out_t=out_f=0, ko=1, err=0, cnt=0.
REQ-033 Capture (CH=4, W=2, SYNC_STAGES=2):
- Stimulus: ki=1; sel_t=10, sel_f=01; channel 2 t=01, f=10; other channels valid DATA.
- Response after 3 clocks: out_t=01, out_f=10, ko=0, cnt=1.
REQ-034 Release: then all rails 0 with ki=0 -> after 3 clocks out_t=out_f=00, ko=1; four full cycles with CW=2 -> cnt returns to 0.
REQ-035 Handshake hold:
- DATA-complete inputs with ki=0 for 10 clocks -> output stays NULL, ko=1.
- Raise ki -> capture on the next edge.
REQ-036 Partial wavefront: sel complete, channel 3 bit 1 both rails 0, ki=1 -> no capture for 20 clocks; completing that pair -> capture 3 clocks later.
REQ-037 Illegal encoding:
- din_t[0]=din_f[0]=1 -> err=1 after 3 clocks; outputs, ko and cnt frozen despite further valid wavefronts.
- rst clears err.
